// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache (one 32-bit word per line) answering the fetcher handshake;
// misses are refilled from the byte-wide RAM port through the memory arbiter.
module icache_fetch_responder #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _InstFetcher_need_inst,
  input  logic [31:0] _pc,
  output logic        _mem_busy,
  output logic        _inst_ready_in,
  output logic [31:0] _inst_in,
  output logic        _icache_mem_req,
  input  logic        _icache_mem_gnt,
  output logic [31:0] _mem_a,
  input  logic [7:0]  _mem_din
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REQ, S_READ} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [23:0]       bytes_q, bytes_d;
  logic              ready_q, ready_d;
  logic [31:0]       inst_q, inst_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W+31:0] line_mem [LINES];
  logic [TAG_W+31:0] line_rd_q;

  logic [31:0]           pc_aligned;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  accept;
  logic                  hit;
  logic                  fill_done;
  logic [31:0]           fill_word;

  assign pc_aligned = _pc & 32'hFFFF_FFFC;
  assign pc_idx     = pc_aligned[INDEX_BITS+1:2];
  assign req_idx    = addr_q[INDEX_BITS+1:2];
  assign req_tag    = addr_q[31:INDEX_BITS+2];
  assign accept     = rdy_in && !_clear && (state_q == S_IDLE) && _InstFetcher_need_inst;
  assign hit        = valid_q[req_idx] && (line_rd_q[TAG_W+31:32] == req_tag);
  assign fill_done  = rdy_in && !_clear && (state_q == S_READ) && (cnt_q == 3'd4);
  // The last byte is still on the RAM bus in the final READ cycle.
  assign fill_word  = {_mem_din, bytes_q};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    ready_d = ready_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (_clear) begin
      state_d = S_IDLE;
      addr_d  = 32'd0;
      cnt_d   = 3'd0;
      bytes_d = 24'd0;
      ready_d = 1'b0;
    end else if (rdy_in) begin
      ready_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (_InstFetcher_need_inst) begin
            addr_d  = pc_aligned;
            state_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            ready_d = 1'b1;
            inst_d  = line_rd_q[31:0];
            state_d = S_IDLE;
          end else begin
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (_icache_mem_gnt) begin
            cnt_d   = 3'd0;
            state_d = S_READ;
          end
        end
        S_READ: begin
          if (cnt_q == 3'd4) begin
            valid_d[req_idx] = 1'b1;
            ready_d = 1'b1;
            inst_d  = fill_word;
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
            case (cnt_q)
              3'd1:    bytes_d[7:0]   = _mem_din;
              3'd2:    bytes_d[15:8]  = _mem_din;
              3'd3:    bytes_d[23:16] = _mem_din;
              default: ;
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      cnt_q   <= 3'd0;
      bytes_q <= 24'd0;
      ready_q <= 1'b0;
      inst_q  <= 32'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
      ready_q <= ready_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data array is read on the accepting edge so LOOKUP sees a registered line.
  always_ff @(posedge clk_in) begin
    if (fill_done) begin
      line_mem[req_idx] <= {req_tag, fill_word};
    end
    if (accept) begin
      line_rd_q <= line_mem[pc_idx];
    end
  end

  assign _mem_busy       = (state_q != S_IDLE);
  assign _inst_ready_in  = ready_q & rdy_in;
  assign _inst_in        = inst_q;
  assign _icache_mem_req = (state_q == S_REQ) || (state_q == S_READ);
  assign _mem_a          = ((state_q == S_READ) && (cnt_q != 3'd4)) ? (addr_q + {29'd0, cnt_q}) : 32'd0;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder: byte RAM model plus a queue of expected fetch words.
module tb_icache_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        need = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        busy;
  logic        ready;
  logic [31:0] inst;
  logic        mem_req;
  logic        gnt = 1'b1;
  logic [31:0] mem_a;
  logic [7:0]  mem_din = 8'd0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int req_cyc = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ram [logic [31:0]];

  icache_fetch_responder #(.INDEX_BITS(6)) dut (
    .clk_in                 (clk),
    .rst_in                 (rst),
    .rdy_in                 (rdy),
    ._clear                 (clear),
    ._InstFetcher_need_inst (need),
    ._pc                    (pc),
    ._mem_busy              (busy),
    ._inst_ready_in         (ready),
    ._inst_in               (inst),
    ._icache_mem_req        (mem_req),
    ._icache_mem_gnt        (gnt),
    ._mem_a                 (mem_a),
    ._mem_din               (mem_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rb(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)};
  endfunction

  // RAM answers one cycle after the address and halts with the rest of the system when rdy is low.
  always @(posedge clk) if (rdy) mem_din <= rb(mem_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_ram(input logic [31:0] a, input logic [31:0] w);
    ram[a]         = w[7:0];
    ram[a + 32'd1] = w[15:8];
    ram[a + 32'd2] = w[23:16];
    ram[a + 32'd3] = w[31:24];
  endtask

  task automatic issue(input logic [31:0] a);
    need = 1'b1;
    pc   = a;
    exp_q.push_back(exp_word({a[31:2], 2'b00}));
    req_cyc = cyc;
    tick();
    need = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int lat, input bit chain, input logic [31:0] chain_pc);
    int n = 0;
    logic [31:0] e;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    if (!ready) begin
      chk({tag, "_timeout"}, {31'd0, ready}, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk({tag, "_data"}, inst, e);
      chk({tag, "_lat"}, cyc - req_cyc, lat);
      if (chain) begin
        need = 1'b1;
        pc   = chain_pc;
        exp_q.push_back(exp_word({chain_pc[31:2], 2'b00}));
        req_cyc = cyc;
      end
      tick();
      need = 1'b0;
      chk({tag, "_pulse"}, {31'd0, ready}, 32'd0);
    end
  endtask

  initial begin
    int pulses;
    set_ram(32'h0000_0000, 32'h0000_0513);
    set_ram(32'h0000_0100, 32'h0010_0093);
    set_ram(32'h0000_0040, 32'h5634_1237);
    set_ram(32'h0000_0080, 32'hA5C3_0F11);
    set_ram(32'h0000_00C0, 32'h7766_5544);
    set_ram(32'hFFFF_FFFC, 32'hDEAD_BEEF);

    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss with grant held high.
    gnt = 1'b1;
    issue(32'h0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("cold_req_c%0d", k), {31'd0, mem_req}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 6) chk($sformatf("cold_a_c%0d", k), mem_a, k - 3);
      if (k == 7) chk("cold_a_cnt4", mem_a, 32'd0);
      if (k < 7) tick();
    end
    wait_resp("cold", 8, 1'b0, 32'd0);

    // Hit, then a back-to-back hit with ignored low pc bits.
    issue(32'h0);
    chk("hit_req", {31'd0, mem_req}, 32'd0);
    wait_resp("hit", 2, 1'b1, 32'h2);
    wait_resp("hit_lowbits", 2, 1'b0, 32'd0);

    // Conflicting tag on index 0 with three grant-wait cycles.
    gnt = 1'b0;
    issue(32'h100);
    tick();
    tick();
    tick();
    chk("gwait_req", {31'd0, mem_req}, 32'd1);
    chk("gwait_busy", {31'd0, busy}, 32'd1);
    chk("gwait_a", mem_a, 32'd0);
    tick();
    gnt = 1'b1;
    wait_resp("conflict", 11, 1'b0, 32'd0);
    issue(32'h0);
    wait_resp("evicted", 8, 1'b0, 32'd0);

    // Flush at cnt=2.
    issue(32'h40);
    tick();
    tick();
    tick();
    tick();
    chk("clr2_a", mem_a, 32'h42);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr2_req", {31'd0, mem_req}, 32'd0);
    chk("clr2_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      pulses += int'(ready);
      tick();
    end
    chk("clr2_no_resp", pulses, 32'd0);
    issue(32'h40);
    wait_resp("clr2_refill", 8, 1'b0, 32'd0);

    // Flush coinciding with cnt=4 must not install the line.
    issue(32'h80);
    for (int i = 0; i < 6; i++) tick();
    chk("clr4_a", mem_a, 32'd0);
    chk("clr4_req", {31'd0, mem_req}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr4_ready", {31'd0, ready}, 32'd0);
    chk("clr4_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    issue(32'h80);
    wait_resp("clr4_refill", 8, 1'b0, 32'd0);

    // Flush together with a request in IDLE drops the request.
    need  = 1'b1;
    pc    = 32'h0;
    clear = 1'b1;
    tick();
    need  = 1'b0;
    clear = 1'b0;
    chk("clridle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("clridle_ready", {31'd0, ready}, 32'd0);

    // rdy_in low for four cycles at cnt=1.
    issue(32'hC0);
    tick();
    tick();
    tick();
    chk("stall_a_pre", mem_a, 32'hC1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_a_%0d", i), mem_a, 32'hC1);
    end
    tick();
    rdy = 1'b1;
    chk("stall_a_post", mem_a, 32'hC1);
    wait_resp("stall", 12, 1'b0, 32'd0);

    // 32-bit address wrap.
    issue(32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_a0", mem_a, 32'hFFFF_FFFC);
    tick();
    tick();
    tick();
    chk("wrap_a3", mem_a, 32'hFFFF_FFFF);
    wait_resp("wrap", 8, 1'b0, 32'd0);

    // Asynchronous reset in the middle of a refill.
    issue(32'h200);
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    chk("arst_inst", inst, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    issue(32'h0);
    chk("arst_lookup_busy", {31'd0, busy}, 32'd1);
    wait_resp("arst_miss", 8, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
